// File: rtl/cv32e40p_regfile_pkg.sv
// Shared types and constants for the integer register file and its scoreboard.
package cv32e40p_regfile_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int NREGS          = 2 ** REG_ADDR_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] regaddr_t;
    typedef logic [REG_DATA_WIDTH-1:0] regdata_t;

    // Address of the hardwired-zero register when it is enabled.
    localparam regaddr_t REG_ZERO = '0;

endpackage

// File: rtl/cv32e40p_regfile_scoreboard.sv
// Per-register busy scoreboard for loads in flight. It has no data path, so
// any register file that needs load tracking can reuse it.
module cv32e40p_regfile_scoreboard
    import cv32e40p_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       set_i,
    input  logic [ADDR_WIDTH-1:0]      set_addr_i,
    input  logic                       clr_i,
    input  logic [ADDR_WIDTH-1:0]      clr_addr_i,
    output logic [(2**ADDR_WIDTH)-1:0] busy_o,
    output logic                       busy_any_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: a clear is applied first so that a same-cycle set to
    // the same register wins (back-to-back loads to one destination).
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_i && clr_addr_i == ADDR_WIDTH'(i)) begin
                busy_d[i] = 1'b0;
            end
            if (set_i && set_addr_i == ADDR_WIDTH'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[ADDR_WIDTH'(REG_ZERO)] = 1'b0;
        end
    end

    // Busy state register; reset forgets every pending load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_any_o = |busy_q;

endmodule

// File: rtl/cv32e40p_regfile_mp.sv
// Integer register file with NUM_READ read ports, ALU write port A, LSU write
// port B, optional write-to-read bypass, optional hardwired x0 and a busy
// scoreboard that lets the decoder stall on outstanding loads.
module cv32e40p_regfile_mp
    import cv32e40p_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 3,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_READ-1:0]            rbusy_o,
    input  logic                           we_a_i,
    input  logic [ADDR_WIDTH-1:0]          waddr_a_i,
    input  logic [DATA_WIDTH-1:0]          wdata_a_i,
    input  logic                           we_b_i,
    input  logic [ADDR_WIDTH-1:0]          waddr_b_i,
    input  logic [DATA_WIDTH-1:0]          wdata_b_i,
    input  logic                           busy_set_i,
    input  logic [ADDR_WIDTH-1:0]          busy_addr_i,
    output logic                           busy_any_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    // Register storage: port B wins over port A on an address conflict, and
    // x0 keeps its reset value when it is hardwired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ZERO_REG != 0 && i == 0) begin
                    mem[i] <= '0;
                end else if (we_b_i && waddr_b_i == ADDR_WIDTH'(i)) begin
                    mem[i] <= wdata_b_i;
                end else if (we_a_i && waddr_a_i == ADDR_WIDTH'(i)) begin
                    mem[i] <= wdata_a_i;
                end
            end
        end
    end

    cv32e40p_regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (busy_set_i),
        .set_addr_i (busy_addr_i),
        .clr_i      (we_b_i),
        .clr_addr_i (waddr_b_i),
        .busy_o     (busy),
        .busy_any_o (busy_any_o)
    );

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        assign ra = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux: bypass sources in priority B, A, storage; x0 and reset
        // force zero. A same-cycle busy_set only shows up next cycle.
        always_comb begin
            rd = mem[ra];
            rb = busy[ra];
            if (BYPASS != 0) begin
                if (we_b_i && waddr_b_i == ra) begin
                    rd = wdata_b_i;
                end else if (we_a_i && waddr_a_i == ra) begin
                    rd = wdata_a_i;
                end
                if (we_b_i && waddr_b_i == ra && !(busy_set_i && busy_addr_i == ra)) begin
                    rb = 1'b0;
                end
            end
            if (ZERO_REG != 0 && ra == ZERO_ADDR) begin
                rd = '0;
                rb = 1'b0;
            end
            if (!rst_n) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign rbusy_o[k]                          = rb;
    end

endmodule

// File: tb/tb_cv32e40p_regfile_mp.sv
// Bench for cv32e40p_regfile_mp: one bypassing and one non-bypassing instance
// share stimulus and are compared against a behavioural register-file model.
module tb_cv32e40p_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;

    logic          clk;
    logic          rst_n;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata_bp, rdata_nb;
    logic [NR-1:0]    rbusy_bp, rbusy_nb;
    logic             busy_any_bp, busy_any_nb;
    logic          we_a, we_b, busy_set;
    logic [AW-1:0] waddr_a, waddr_b, busy_addr;
    logic [DW-1:0] wdata_a, wdata_b;

    // reference model state
    logic [DW-1:0] mem_m [32];
    logic          busy_m [32];

    int checks;
    int failures;

    cv32e40p_regfile_mp #(.BYPASS(1)) u_dut_bp (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_bp),
        .rbusy_o(rbusy_bp), .we_a_i(we_a), .waddr_a_i(waddr_a),
        .wdata_a_i(wdata_a), .we_b_i(we_b), .waddr_b_i(waddr_b),
        .wdata_b_i(wdata_b), .busy_set_i(busy_set), .busy_addr_i(busy_addr),
        .busy_any_o(busy_any_bp)
    );

    cv32e40p_regfile_mp #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_nb),
        .rbusy_o(rbusy_nb), .we_a_i(we_a), .waddr_a_i(waddr_a),
        .wdata_a_i(wdata_a), .we_b_i(we_b), .waddr_b_i(waddr_b),
        .wdata_b_i(wdata_b), .busy_set_i(busy_set), .busy_addr_i(busy_addr),
        .busy_any_o(busy_any_nb)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rdata(input bit bp, input logic [AW-1:0] a);
        if (!rst_n || a == 0) return '0;
        if (bp && we_b && waddr_b == a) return wdata_b;
        if (bp && we_a && waddr_a == a) return wdata_a;
        return mem_m[a];
    endfunction

    function automatic logic exp_rbusy(input bit bp, input logic [AW-1:0] a);
        if (!rst_n || a == 0) return 1'b0;
        if (bp && we_b && waddr_b == a && !(busy_set && busy_addr == a)) return 1'b0;
        return busy_m[a];
    endfunction

    function automatic logic exp_any();
        logic any;
        any = 1'b0;
        for (int i = 0; i < 32; i++) any = any | busy_m[i];
        return any;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
    endtask

    // state change at a clock edge, written from the behavioural rules
    task automatic model_edge();
        if (we_a && waddr_a != 0) mem_m[waddr_a] = wdata_a;
        if (we_b && waddr_b != 0) mem_m[waddr_b] = wdata_b;
        if (we_b) busy_m[waddr_b] = 1'b0;
        if (busy_set && busy_addr != 0) busy_m[busy_addr] = 1'b1;
    endtask

    task automatic check_all();
        logic [AW-1:0] a;
        for (int k = 0; k < NR; k++) begin
            a = raddr[k*AW +: AW];
            check_eq($sformatf("bp_rdata%0d_x%0d", k, a), rdata_bp[k*DW +: DW], exp_rdata(1'b1, a));
            check_eq($sformatf("nb_rdata%0d_x%0d", k, a), rdata_nb[k*DW +: DW], exp_rdata(1'b0, a));
            check_eq($sformatf("bp_rbusy%0d_x%0d", k, a), {31'd0, rbusy_bp[k]}, {31'd0, exp_rbusy(1'b1, a)});
            check_eq($sformatf("nb_rbusy%0d_x%0d", k, a), {31'd0, rbusy_nb[k]}, {31'd0, exp_rbusy(1'b0, a)});
        end
        check_eq("bp_busy_any", {31'd0, busy_any_bp}, {31'd0, exp_any()});
        check_eq("nb_busy_any", {31'd0, busy_any_nb}, {31'd0, exp_any()});
    endtask

    // called just after a falling edge with inputs driven
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        we_a = 0; waddr_a = '0; wdata_a = '0;
        we_b = 0; waddr_b = '0; wdata_b = '0;
        busy_set = 0; busy_addr = '0;
    endtask

    task automatic read3(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        raddr = {r2, r1, r0};
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        idle();
        read3(5'd1, 5'd2, 5'd3);
        model_clear();
        @(negedge clk);
        cycle();
        rst_n = 1'b1;

        // all registers read zero and idle after reset
        for (int i = 1; i < 32; i++) begin
            read3(AW'(i), AW'(i), AW'(i));
            cycle();
        end

        // write x5 via A, read it next cycle
        we_a = 1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; read3(5'd5, 5'd1, 5'd0);
        cycle();
        idle();
        cycle();

        // x0 writes and busy_set are ignored, also under bypass
        we_a = 1; waddr_a = 5'd0; wdata_a = 32'h12345678;
        we_b = 1; waddr_b = 5'd0; wdata_b = 32'h12345678;
        busy_set = 1; busy_addr = 5'd0; read3(5'd0, 5'd0, 5'd0);
        cycle();
        idle();
        cycle();

        // same-address conflict: port B wins
        we_a = 1; waddr_a = 5'd7; wdata_a = 32'h1111;
        we_b = 1; waddr_b = 5'd7; wdata_b = 32'h2222; read3(5'd7, 5'd7, 5'd5);
        cycle();
        idle();
        cycle();

        // bypass of a port A write
        we_a = 1; waddr_a = 5'd3; wdata_a = 32'hA5A5A5A5; read3(5'd3, 5'd7, 5'd3);
        cycle();
        idle();
        cycle();

        // scoreboard sequence on x9
        busy_set = 1; busy_addr = 5'd9; read3(5'd9, 5'd9, 5'd9);
        cycle();
        idle();
        cycle();
        we_a = 1; waddr_a = 5'd9; wdata_a = 32'h77;
        cycle();
        idle();
        we_b = 1; waddr_b = 5'd9; wdata_b = 32'h55;
        cycle();
        idle();
        cycle();
        busy_set = 1; busy_addr = 5'd9; we_b = 1; waddr_b = 5'd9; wdata_b = 32'h66;
        cycle();
        idle();
        cycle();
        busy_set = 1; busy_addr = 5'd9;
        cycle();
        idle();
        cycle();

        // mid-operation reset clears everything at once
        we_a = 1; waddr_a = 5'd4; wdata_a = 32'h99; busy_set = 1; busy_addr = 5'd4;
        read3(5'd4, 5'd9, 5'd7);
        cycle();
        idle();
        cycle();
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all();
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        cycle();

        // randomized traffic concentrated on a few registers to provoke conflicts
        for (int n = 0; n < 400; n++) begin
            we_a      = 1'($urandom_range(0, 1));
            waddr_a   = AW'($urandom_range(0, 7));
            wdata_a   = $urandom;
            we_b      = ($urandom_range(0, 3) == 0);
            waddr_b   = AW'($urandom_range(0, 7));
            wdata_b   = $urandom;
            busy_set  = ($urandom_range(0, 3) == 0);
            busy_addr = AW'($urandom_range(0, 7));
            read3(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
